code_bank: RTL and testbench

CODE_BANK -- requirements
Module: code_bank

---
 rtl/code_pkg.sv | 14 +
 rtl/code_chan.sv | 69 ++++++
 rtl/code_bank.sv | 106 ++++++++++
 tb/tb_code_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/code_pkg.sv
// Shared encodings for the code_bank counter array: operation codes and FSM states.
package code_pkg;

  localparam logic [1:0] MODE_INC   = 2'b00;
  localparam logic [1:0] MODE_DEC   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_SWEEP = 2'b11;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SWEEP = 1'b1;

endpackage

// File: rtl/code_chan.sv
// One counter channel: value register, INC/DEC/LOAD next-value logic with wrap or
// saturate behaviour, and a sticky wrap/saturation flag cleared only by LOAD or reset.
module code_chan
  import code_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             flag,
  output logic [WIDTH-1:0] next_value_c
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] value_q, value_d;
  logic             flag_q, flag_d;

  // Boundary hits set the flag; SAT picks between holding and wrapping.
  always_comb begin
    value_d = value_q;
    flag_d  = flag_q;
    if (op_en) begin
      case (op)
        MODE_INC: begin
          if (value_q == ALL_ONES) begin
            flag_d = 1'b1;
            if (SAT == 0) value_d = '0;
          end else begin
            value_d = value_q + WIDTH'(1);
          end
        end
        MODE_DEC: begin
          if (value_q == '0) begin
            flag_d = 1'b1;
            if (SAT == 0) value_d = ALL_ONES;
          end else begin
            value_d = value_q - WIDTH'(1);
          end
        end
        MODE_LOAD: begin
          value_d = load_val;
          flag_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      flag_q  <= flag_d;
    end
  end

  assign value        = value_q;
  assign flag         = flag_q;
  assign next_value_c = value_d;

endmodule

// File: rtl/code_bank.sv
// Bank of N independent counter channels with single-channel ops and a SWEEP
// that increments every channel in order, one per enabled cycle.
module code_bank
  import code_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SAT   = 0,
  localparam int unsigned SW   = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [SW-1:0]      Slt,
  input  logic               En,
  input  logic [1:0]         Mode,
  input  logic [WIDTH-1:0]   LoadVal,
  output logic [N*WIDTH-1:0] Outputs,
  output logic [WIDTH-1:0]   SelOut,
  output logic [N-1:0]       Flag,
  output logic               Busy
);

  state_t           state_q, state_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] sel_out_q, sel_out_d;
  logic [N-1:0]     chan_en_c;
  logic [1:0]       chan_op_c;
  logic [WIDTH-1:0] chan_next_c [N];

  // Select/sweep control: decides which channel (if any) executes this cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    chan_en_c = '0;
    chan_op_c = MODE_INC;
    case (state_q)
      ST_IDLE: begin
        if (En) begin
          if (Mode == MODE_SWEEP) begin
            state_d = ST_SWEEP;
            ptr_d   = '0;
          end else begin
            chan_op_c = Mode;
            for (int unsigned k = 0; k < N; k++) begin
              if (Slt == SW'(k)) chan_en_c[k] = 1'b1;
            end
          end
        end
      end
      ST_SWEEP: begin
        if (En) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (ptr_q == SW'(k)) chan_en_c[k] = 1'b1;
          end
          if (ptr_q == SW'(N - 1)) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SelOut captures the new value of whichever channel executed; otherwise holds.
  always_comb begin
    sel_out_d = sel_out_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (chan_en_c[k]) sel_out_d = chan_next_c[k];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      sel_out_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_out_q <= sel_out_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_chan
    code_chan #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_chan (
      .clk          (Clk),
      .reset        (Reset),
      .op_en        (chan_en_c[k]),
      .op           (chan_op_c),
      .load_val     (LoadVal),
      .value        (Outputs[k*WIDTH +: WIDTH]),
      .flag         (Flag[k]),
      .next_value_c (chan_next_c[k])
    );
  end

  assign SelOut = sel_out_q;
  assign Busy   = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_code_bank.sv
// Bench for code_bank: three configurations driven in lockstep and checked every
// cycle against an arithmetic model of the counter bank.
module tb_code_bank;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         En;
  logic [1:0]   Mode;
  logic [1:0]   Slt;
  logic [7:0]   LoadVal8;
  logic [63:0]  LoadVal64;

  logic [31:0]  o0;  logic [7:0]  s0;  logic [3:0] f0;  logic b0;
  logic [23:0]  o1;  logic [7:0]  s1;  logic [2:0] f1;  logic b1;
  logic [127:0] o2;  logic [63:0] s2;  logic [1:0] f2;  logic b2;

  always #5 Clk = ~Clk;

  code_bank #(.N(4), .WIDTH(8), .SAT(0)) u_bank0 (
    .Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En), .Mode(Mode), .LoadVal(LoadVal8),
    .Outputs(o0), .SelOut(s0), .Flag(f0), .Busy(b0));

  code_bank #(.N(3), .WIDTH(8), .SAT(1)) u_bank1 (
    .Clk(Clk), .Reset(Reset), .Slt(Slt), .En(En), .Mode(Mode), .LoadVal(LoadVal8),
    .Outputs(o1), .SelOut(s1), .Flag(f1), .Busy(b1));

  code_bank u_bank2 (
    .Clk(Clk), .Reset(Reset), .Slt(Slt[0]), .En(En), .Mode(Mode), .LoadVal(LoadVal64),
    .Outputs(o2), .SelOut(s2), .Flag(f2), .Busy(b2));

  int unsigned mn   [3] = '{4, 3, 2};
  int unsigned mw   [3] = '{8, 8, 64};
  bit          msat [3] = '{1'b0, 1'b1, 1'b0};
  logic [63:0] mval [3][16];
  bit          mflag[3][16];
  bit          mbusy[3];
  int unsigned mptr [3];
  logic [63:0] msel [3];

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Execute one channel operation on the model using integer range arithmetic.
  task automatic apply(input int d, input int unsigned ch, input logic [1:0] op,
                       input logic [63:0] lv);
    logic [64:0] top;
    logic [64:0] v;
    top = (65'd1 << mw[d]) - 65'd1;
    v   = {1'b0, mval[d][ch]};
    case (op)
      2'd0: if (v + 65'd1 > top) begin mflag[d][ch] = 1'b1; v = msat[d] ? top : 65'd0; end
            else v = v + 65'd1;
      2'd1: if (v == 65'd0) begin mflag[d][ch] = 1'b1; v = msat[d] ? 65'd0 : top; end
            else v = v - 65'd1;
      2'd2: begin v = {1'b0, lv} & top; mflag[d][ch] = 1'b0; end
      default: ;
    endcase
    mval[d][ch] = v[63:0];
    msel[d]     = v[63:0];
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int unsigned sl;
      logic [63:0] lv;
      sl = (d == 2) ? 32'(Slt[0]) : 32'(Slt);
      lv = (d == 2) ? LoadVal64 : {56'd0, LoadVal8};
      if (Reset) begin
        for (int k = 0; k < 16; k++) begin mval[d][k] = '0; mflag[d][k] = 1'b0; end
        mbusy[d] = 1'b0; mptr[d] = 0; msel[d] = '0;
      end else if (mbusy[d]) begin
        if (En) begin
          apply(d, mptr[d], 2'd0, lv);
          if (mptr[d] == mn[d] - 1) begin mbusy[d] = 1'b0; mptr[d] = 0; end
          else mptr[d] = mptr[d] + 1;
        end
      end else if (En) begin
        if (Mode == 2'd3) begin mbusy[d] = 1'b1; mptr[d] = 0; end
        else if (sl < mn[d]) apply(d, sl, Mode, lv);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      logic [127:0] eo, oo;
      logic [15:0]  ef, fo;
      logic [63:0]  so;
      logic         bo;
      eo = '0; ef = '0;
      for (int k = 0; k < int'(mn[d]); k++) begin
        eo = eo | (128'(mval[d][k]) << (k * int'(mw[d])));
        ef = ef | (16'(mflag[d][k]) << k);
      end
      case (d)
        0:       begin oo = 128'(o0); fo = 16'(f0); so = 64'(s0); bo = b0; end
        1:       begin oo = 128'(o1); fo = 16'(f1); so = 64'(s1); bo = b1; end
        default: begin oo = o2;       fo = 16'(f2); so = s2;      bo = b2; end
      endcase
      chk($sformatf("%s u%0d Outputs", tag, d), oo, eo);
      chk($sformatf("%s u%0d Flag", tag, d), 128'(fo), 128'(ef));
      chk($sformatf("%s u%0d SelOut", tag, d), 128'(so), 128'(msel[d]));
      chk($sformatf("%s u%0d Busy", tag, d), 128'(bo), 128'(mbusy[d]));
    end
  endtask

  task automatic cyc(input string tag, input bit r, input bit e, input logic [1:0] m,
                     input logic [1:0] s, input logic [63:0] lv);
    Reset = r; En = e; Mode = m; Slt = s; LoadVal8 = lv[7:0]; LoadVal64 = lv;
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  function automatic logic [63:0] rand_lv();
    case ($urandom_range(0, 3))
      0:       return 64'd0;
      1:       return '1;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    // Reset, then three INCs on channel 1
    cyc("rst", 1'b1, 1'b0, 2'd0, 2'd0, 64'd0);
    chk("rst busy", 128'(b0), 128'd0);
    repeat (3) cyc("inc", 1'b0, 1'b1, 2'd0, 2'd1, 64'd0);
    chk("inc3 outputs", 128'(o0), 128'h0000_0300);
    chk("inc3 selout", 128'(s0), 128'd3);
    chk("inc3 flag", 128'(f0), 128'd0);

    // Wrap vs saturate on channel 2, then LOAD clears the flag
    cyc("load ff", 1'b0, 1'b1, 2'd2, 2'd2, 64'hFF);
    cyc("inc ff", 1'b0, 1'b1, 2'd0, 2'd2, 64'd0);
    chk("wrap ch2", 128'(o0[23:16]), 128'h00);
    chk("wrap flag2", 128'(f0[2]), 128'd1);
    chk("sat ch2", 128'(o1[23:16]), 128'hFF);
    chk("sat flag2", 128'(f1[2]), 128'd1);
    cyc("load 10", 1'b0, 1'b1, 2'd2, 2'd2, 64'h10);
    chk("load clr flag2", 128'(f0[2]), 128'd0);
    chk("load clr flag2 sat", 128'(f1[2]), 128'd0);

    // DEC underflow on channel 0; out-of-range select on the N=3 bank
    cyc("dec 0", 1'b0, 1'b1, 2'd1, 2'd0, 64'd0);
    chk("dec wrap ch0", 128'(o0[7:0]), 128'hFF);
    chk("dec wrap flag0", 128'(f0[0]), 128'd1);
    cyc("slt oob", 1'b0, 1'b1, 2'd2, 2'd3, 64'h55);
    chk("slt oob selout", 128'(s1), 128'h00);

    // Full sweep with En high and control inputs toggling
    cyc("rst2", 1'b1, 1'b0, 2'd0, 2'd0, 64'd0);
    cyc("sweep req", 1'b0, 1'b1, 2'd3, 2'd0, 64'd0);
    chk("sweep busy rise", 128'(b0), 128'd1);
    for (int i = 0; i < 4; i++) begin
      cyc("sweep", 1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rand_lv());
      chk("sweep selout", 128'(s0), 128'd1);
      chk("sweep busy", 128'(b0), (i < 3) ? 128'd1 : 128'd0);
    end
    chk("sweep final", 128'(o0), 128'h0101_0101);

    // Sweep paused on its second cycle
    cyc("rst3", 1'b1, 1'b0, 2'd0, 2'd0, 64'd0);
    cyc("sweep2 req", 1'b0, 1'b1, 2'd3, 2'd0, 64'd0);
    cyc("sweep2 c1", 1'b0, 1'b1, 2'd0, 2'd0, 64'd0);
    cyc("sweep2 pause", 1'b0, 1'b0, 2'd3, 2'd2, 64'd0);
    chk("pause busy", 128'(b0), 128'd1);
    chk("pause outputs", 128'(o0), 128'h0000_0001);
    repeat (3) cyc("sweep2 run", 1'b0, 1'b1, 2'd2, 2'd1, 64'hAA);
    chk("sweep2 busy fall", 128'(b0), 128'd0);
    chk("sweep2 final", 128'(o0), 128'h0101_0101);

    // Reset aborts a sweep; wide default-parameter bank
    cyc("rst4", 1'b1, 1'b0, 2'd0, 2'd0, 64'd0);
    cyc("sweep3 req", 1'b0, 1'b1, 2'd3, 2'd0, 64'd0);
    cyc("sweep3 c1", 1'b0, 1'b1, 2'd0, 2'd0, 64'd0);
    cyc("sweep3 rst", 1'b1, 1'b1, 2'd3, 2'd0, 64'd0);
    chk("abort outputs", 128'(o0), 128'd0);
    chk("abort busy", 128'(b0), 128'd0);
    chk("abort selout", 128'(s0), 128'd0);
    cyc("wide inc", 1'b0, 1'b1, 2'd0, 2'd1, 64'd0);
    chk("wide ch1", 128'(o2[127:64]), 128'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rand_lv());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
